mcu_link_tx_sched: RTL
======================

Name: mcu_link_tx_sched

Overview:
MCU-side transmit scheduler for the 4-bit MCU-to-ROCSTAR link of one ROCSTAR port. It arbitrates three sources onto the single nibble stream:
- coincidence verdicts (NCOIN/PCOIN/DCOIN), queued in a small FIFO, highest priority;
- 16-bit special-word commands sent as SPECL plus 4 nibbles;
- the IDLE0..IDLE3 filler cycle.

It guarantees the stream that the ROCSTAR receiver decodes without idle-sequence errors.

Parameters:
COIN_DEPTH, 4, coincidence FIFO depth in entries (power of two, 2..16).
SP_GAP, 4, minimum number of idle words emitted after a special sequence before another special request is accepted.

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous reset, active-high
coin_valid  in  1  pulse: one coincidence verdict to send this cycle
coin_type  in  2  00=NCOIN, 01=PCOIN, 10=DCOIN, 11=NCOIN
sp_valid  in  1  special-word request, held until accepted
sp_word  in  16  special-word payload, stable while sp_valid=1
sp_ready  out  1  combinational; accept occurs when sp_valid && sp_ready
to_rocstar  out  4  registered link nibble
busy_sp  out  1  high while a special sequence occupies the link
n_coin_sent  out  16  coincidence words emitted, wraps
n_sp_sent  out  16  special sequences completed, wraps
n_coin_drop  out  16  verdicts dropped on FIFO overflow, wraps

Behaviour:
- Codes: IDLE0=0111, IDLE1=1011, IDLE2=1101, IDLE3=1110, NCOIN=1001, PCOIN=0011, DCOIN=0110, SPECL=1100.
- Reset (sync, active-high, wins over all other activity):
  - to_rocstar=1110 (IDLE3); FIFO emptied; state IDLE; next idle phase IDLE0.
  - Gap counter=SP_GAP, so no special request is accepted until SP_GAP idle words have been sent.
  - busy_sp=0, all counters=0.
  - Reset mid-sequence abandons the sequence; it is not counted in n_sp_sent.
- State machine: IDLE, SP_HDR, SP_N3, SP_N2, SP_N1, SP_N0. Each state emits exactly one word, on the registered to_rocstar of the following cycle.
- IDLE: per cycle, choose the word in this order:
  - (a) Coincidence. If the FIFO is non-empty, pop its head and emit the code. Otherwise, if coin_valid, emit the incoming verdict directly (bypass; the verdict is not written to the FIFO). Increment n_coin_sent. Latency with empty FIFO: request in cycle k, code on to_rocstar in cycle k+1.
  - (b) Special request. Else, if sp_valid && sp_ready: latch sp_word, emit SPECL, go to SP_N3.
  - (c) Idle. Else emit the next idle word in the cycle and advance the phase (IDLE3 is followed by IDLE0).
- sp_ready = (state==IDLE) && FIFO empty && !coin_valid && gap counter==0. Coincidences always pre-empt the start of a special sequence.
- SP_N3..SP_N0 emit payload[15:12], [11:8], [7:4], [3:0] on consecutive cycles. They are never interrupted. Verdicts arriving meanwhile are pushed into the FIFO.
  - After SP_N0: return to IDLE, increment n_sp_sent, load gap counter with SP_GAP.
- busy_sp=1 while the registered output is SPECL or a payload nibble.
- Idle phase after any non-idle word:
  - Normally resume at IDLE0.
  - Exception: if the last payload nibble equals IDLE0 (0111), resume at IDLE1, so the receiver never sees IDLE0 followed by IDLE0.
- Gap counter: decrements only on cycles that emit an idle word; saturates at 0.
- FIFO, on push when full:
  - Without a same-cycle pop, the new verdict is dropped and n_coin_drop increments.
  - Simultaneous pop and push when full is legal: no drop, count unchanged.
- Type 11 is transmitted as NCOIN.
- Counters wrap 0xFFFF to 0x0000.

Test Plan:
1. Reset, then 12 cycles with no requests -> to_rocstar sequence 0111, 1011, 1101, 1110 repeated three times. sp_ready=0 for the first 4 idle cycles, then 1.
2. coin_valid with coin_type=10 at cycle k, FIFO empty -> to_rocstar=0110 at k+1, then 0111 at k+2. n_coin_sent=1.
3. sp_word=0x2222 accepted -> 1100, 0010, 0010, 0010, 0010, then 0111. busy_sp high for 5 cycles. n_sp_sent=1. sp_ready low for the following 4 idle cycles.
4. During a 0x1111 sequence, verdicts 01, 00, 10 arrive on three consecutive cycles -> after the final 0001 nibble, the link emits 0011, 1001, 0110, then 0111. No drops.
5. COIN_DEPTH=4: 6 verdicts arrive while a special sequence is running -> one word is drained per cycle starting the cycle after the sequence ends, and n_coin_drop equals the verdicts pushed while full without a same-cycle pop. Also hold sp_valid with coin_valid asserted every cycle -> no SPECL emitted until coin_valid drops.
6. sp_word=0x1237 -> payload nibbles end with 0111 and the next word is 1011. Separately, assert rst in the SP_N2 cycle -> next output 1110, then 0111, and n_sp_sent is unchanged.

Source files
------------

// File: rtl/mcu_link_tx_sched.sv
// MCU->ROCSTAR nibble-link scheduler: coincidences > special words > IDLE0..3 filler.
// One word per cycle, registered (1-cycle latency); specials gated by sp_ready, verdicts queue or drop.
module mcu_link_tx_sched #(
    parameter int COIN_DEPTH = 4,
    parameter int SP_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        sp_valid,
    input  logic [15:0] sp_word,
    output logic        sp_ready,
    output logic [3:0]  to_rocstar,
    output logic        busy_sp,
    output logic [15:0] n_coin_sent,
    output logic [15:0] n_sp_sent,
    output logic [15:0] n_coin_drop
);

    localparam int AW = (COIN_DEPTH > 1) ? $clog2(COIN_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (SP_GAP > 0) ? $clog2(SP_GAP + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(COIN_DEPTH);
    localparam logic [GW-1:0] GAP_INIT = GW'(SP_GAP);

    localparam logic [3:0] IDLE0 = 4'b0111;
    localparam logic [3:0] IDLE1 = 4'b1011;
    localparam logic [3:0] IDLE2 = 4'b1101;
    localparam logic [3:0] IDLE3 = 4'b1110;
    localparam logic [3:0] NCOIN = 4'b1001;
    localparam logic [3:0] PCOIN = 4'b0011;
    localparam logic [3:0] DCOIN = 4'b0110;
    localparam logic [3:0] SPECL = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SP_HDR,
        ST_SP_N3,
        ST_SP_N2,
        ST_SP_N1,
        ST_SP_N0
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      fifo_mem [COIN_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty, fifo_full, fifo_pop, fifo_wr;
    logic            coin_push, coin_drop, coin_emit;
    logic [15:0]     sp_lat;
    logic [1:0]      idle_ph, idle_ph_nxt;
    logic [GW-1:0]   gap_cnt;
    logic            gap_dec, gap_load;
    logic [3:0]      word_nxt;
    logic            busy_nxt, sp_accept, sp_done;

    function automatic logic [3:0] coin_code(input logic [1:0] t);
        case (t)
            2'b01:   return PCOIN;
            2'b10:   return DCOIN;
            default: return NCOIN;
        endcase
    endfunction

    function automatic logic [3:0] idle_code(input logic [1:0] ph);
        case (ph)
            2'd0:    return IDLE0;
            2'd1:    return IDLE1;
            2'd2:    return IDLE2;
            default: return IDLE3;
        endcase
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign sp_ready   = (state == ST_IDLE) && fifo_empty && !coin_valid && (gap_cnt == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_wr    = coin_push && (!fifo_full || fifo_pop);
    assign coin_drop  = coin_push && fifo_full && !fifo_pop;

    always_comb begin
        state_nxt   = state;
        word_nxt    = idle_code(idle_ph);
        busy_nxt    = 1'b0;
        idle_ph_nxt = idle_ph;
        fifo_pop    = 1'b0;
        coin_push   = 1'b0;
        coin_emit   = 1'b0;
        sp_accept   = 1'b0;
        sp_done     = 1'b0;
        gap_dec     = 1'b0;
        gap_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    coin_push   = coin_valid;
                    coin_emit   = 1'b1;
                    word_nxt    = coin_code(fifo_mem[rd_ptr]);
                    idle_ph_nxt = 2'd0;
                end else if (coin_valid) begin
                    coin_emit   = 1'b1;
                    word_nxt    = coin_code(coin_type);
                    idle_ph_nxt = 2'd0;
                end else if (sp_valid && sp_ready) begin
                    sp_accept   = 1'b1;
                    word_nxt    = SPECL;
                    busy_nxt    = 1'b1;
                    idle_ph_nxt = 2'd0;
                    state_nxt   = ST_SP_N3;
                end else begin
                    gap_dec     = 1'b1;
                    idle_ph_nxt = idle_ph + 2'd1;
                end
            end
            ST_SP_HDR: begin
                word_nxt  = SPECL;
                busy_nxt  = 1'b1;
                coin_push = coin_valid;
                state_nxt = ST_SP_N3;
            end
            ST_SP_N3: begin
                word_nxt  = sp_lat[15:12];
                busy_nxt  = 1'b1;
                coin_push = coin_valid;
                state_nxt = ST_SP_N2;
            end
            ST_SP_N2: begin
                word_nxt  = sp_lat[11:8];
                busy_nxt  = 1'b1;
                coin_push = coin_valid;
                state_nxt = ST_SP_N1;
            end
            ST_SP_N1: begin
                word_nxt  = sp_lat[7:4];
                busy_nxt  = 1'b1;
                coin_push = coin_valid;
                state_nxt = ST_SP_N0;
            end
            ST_SP_N0: begin
                word_nxt    = sp_lat[3:0];
                busy_nxt    = 1'b1;
                coin_push   = coin_valid;
                sp_done     = 1'b1;
                gap_load    = 1'b1;
                // Never let the receiver see IDLE0 twice in a row.
                idle_ph_nxt = (sp_lat[3:0] == IDLE0) ? 2'd1 : 2'd0;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            to_rocstar  <= IDLE3;
            busy_sp     <= 1'b0;
            idle_ph     <= 2'd0;
            sp_lat      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            gap_cnt     <= GAP_INIT;
            n_coin_sent <= '0;
            n_sp_sent   <= '0;
            n_coin_drop <= '0;
        end else begin
            state      <= state_nxt;
            to_rocstar <= word_nxt;
            busy_sp    <= busy_nxt;
            idle_ph    <= idle_ph_nxt;
            if (sp_accept)
                sp_lat <= sp_word;
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(fifo_pop);
            if (gap_load)
                gap_cnt <= GAP_INIT;
            else if (gap_dec && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (coin_emit)
                n_coin_sent <= n_coin_sent + 16'd1;
            if (sp_done)
                n_sp_sent <= n_sp_sent + 16'd1;
            if (coin_drop)
                n_coin_drop <= n_coin_drop + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= coin_type;
    end

endmodule
